adxl362_controller: RTL and testbench
=====================================

# adxl362_controller

Register-access sequencer that sits directly upstream of the SPI controller and drives its start/data/hold-CS interface to perform complete ADXL362 accelerometer register transactions. Each request is one 3-byte SPI transfer: command byte, register address, data byte, with chip select held low across all three bytes. The block consumes the SPI controller's done/received-data outputs and returns a single completion pulse plus the read byte to the user logic above it.

## Interface
Parameters:
- WRITE_CMD, 8'h0A, command byte sent for register writes
- READ_CMD, 8'h0B, command byte sent for register reads

Ports (one clock `clk`; `rst` is synchronous and active-high):
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  request a register transaction; sampled only in IDLE
- write  input  1  1 = register write, 0 = register read; latched with start
- address  input  8  register address; latched with start
- data_to_send  input  8  write data; latched with start, ignored for reads
- busy  output  1  transaction in progress
- done  output  1  one-cycle pulse at transaction completion
- data_received  output  8  last read data; holds value between reads
- spi_start  output  1  one-cycle start pulse to SPI controller
- spi_data  output  8  byte presented to SPI controller
- spi_hold_cs  output  1  hold-CS request to SPI controller for current byte
- spi_done  input  1  SPI controller byte-complete pulse
- spi_data_received  input  8  byte returned by SPI controller, valid with spi_done

## Operation
- Registered outputs only; all state changes on rising `clk`.
- States: IDLE, CMD, CMD_WAIT, ADDR, ADDR_WAIT, DATA, DATA_WAIT, DONE.
- IDLE: busy=0. start=1 -> latch write/address/data_to_send, go CMD.
- CMD: spi_start=1 for exactly this cycle, spi_data = write ? WRITE_CMD : READ_CMD, spi_hold_cs=1; go CMD_WAIT.
- CMD_WAIT: hold spi_data/spi_hold_cs stable; on spi_done go ADDR.
- ADDR: spi_start=1, spi_data=latched address, spi_hold_cs=1; go ADDR_WAIT; on spi_done go DATA.
- DATA: spi_start=1, spi_data = write ? latched data : 8'h00, spi_hold_cs=0 (CS released after final byte); go DATA_WAIT.
- DATA_WAIT: on spi_done, if read then data_received <= spi_data_received; go DONE.
- DONE: done=1 for one cycle; go IDLE.
- busy=1 in every state except IDLE; done never coincides with busy=0 except in DONE... (busy=1 in DONE, falls next cycle).
- start while not in IDLE is ignored (not queued).
- spi_done seen in CMD, ADDR, DATA, DONE or IDLE is ignored.
- Write transactions leave data_received unchanged.

## Timing
- Reset values: busy=0, done=0, data_received=8'h00, spi_start=0, spi_data=8'h00, spi_hold_cs=0, state IDLE.
- start sampled cycle N -> busy=1 and spi_start=1 in cycle N+1.
- Each byte: spi_start pulse, then wait for spi_done (latency set by SPI controller); next byte's spi_start asserted the cycle after spi_done is sampled.
- Total latency from start to done = 4 + sum of the three SPI byte latencies (cycles from each spi_start to its spi_done) cycles.
- spi_hold_cs is valid from the cycle spi_start is asserted until spi_done for that byte; it is 1 for command and address bytes, 0 for data byte.
- done asserted the cycle after final spi_done; data_received valid in the same cycle as done and thereafter.
- New start accepted the cycle after done (back-to-back transactions allowed; minimum one IDLE cycle).
- rst asserted mid-transaction: next edge forces all outputs to reset values; no done pulse; an in-flight SPI byte is abandoned (spi_hold_cs=0 releases CS after it).

## Test plan
- Write: start, write=1, address=8'h2D, data=8'h02 -> spi_data sequence 8'h0A, 8'h2D, 8'h02; spi_hold_cs 1,1,0; exactly three spi_start pulses; one done pulse; data_received unchanged (8'h00).
- Read: start, write=0, address=8'h00, subunit model returns 8'hAD on third byte -> spi_data 8'h0B, 8'h00, 8'h00; done pulse; data_received=8'hAD held until next read.
- Start during busy: pulse start with address=8'h1F mid CMD_WAIT -> ignored, transaction completes with original address, only one done.
- Back-to-back: read 8'h01 (returns 8'h1D) then read 8'h02 (returns 8'hF2) issued the cycle after first done -> two done pulses, data_received 8'h1D then 8'hF2.
- Spurious spi_done in IDLE and in ADDR state -> no state advance, no extra spi_start.
- Reset mid ADDR_WAIT -> next cycle busy=0, spi_start=0, spi_hold_cs=0, data_received=8'h00, no done; subsequent write completes normally.

Source files
------------

// File: rtl/adxl362_controller.sv
// adxl362_controller: sequences one 3-byte ADXL362 register transaction
// (command, address, data) over a byte-level SPI controller interface.
// Chip select is held across the command and address bytes and released
// after the data byte. All outputs are registered.
module adxl362_controller #(
  parameter logic [7:0] WRITE_CMD = 8'h0A,
  parameter logic [7:0] READ_CMD  = 8'h0B
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       write,
  input  logic [7:0] address,
  input  logic [7:0] data_to_send,
  output logic       busy,
  output logic       done,
  output logic [7:0] data_received,
  output logic       spi_start,
  output logic [7:0] spi_data,
  output logic       spi_hold_cs,
  input  logic       spi_done,
  input  logic [7:0] spi_data_received
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CMD       = 3'd1,
    S_CMD_WAIT  = 3'd2,
    S_ADDR      = 3'd3,
    S_ADDR_WAIT = 3'd4,
    S_DATA      = 3'd5,
    S_DATA_WAIT = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic        write_r;
  logic [7:0]  address_r;
  logic [7:0]  data_r;
  logic        launch_s;
  logic [7:0]  byte_s;
  logic        hold_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; spi_done only advances the FSM from the *_WAIT states.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          next_state_s = S_CMD;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_CMD:       next_state_s = S_CMD_WAIT;
      S_CMD_WAIT: begin
        if (spi_done) begin
          next_state_s = S_ADDR;
        end else begin
          next_state_s = S_CMD_WAIT;
        end
      end
      S_ADDR:      next_state_s = S_ADDR_WAIT;
      S_ADDR_WAIT: begin
        if (spi_done) begin
          next_state_s = S_DATA;
        end else begin
          next_state_s = S_ADDR_WAIT;
        end
      end
      S_DATA:      next_state_s = S_DATA_WAIT;
      S_DATA_WAIT: begin
        if (spi_done) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_DATA_WAIT;
        end
      end
      S_DONE:      next_state_s = S_IDLE;
      default:     next_state_s = S_IDLE;
    endcase
  end

  // Byte to launch when entering a byte state. The command byte is chosen
  // from the live write input because it is latched on the same edge.
  always_comb begin
    launch_s = 1'b0;
    byte_s   = 8'h00;
    hold_s   = 1'b0;
    case (next_state_s)
      S_CMD: begin
        launch_s = 1'b1;
        byte_s   = write ? WRITE_CMD : READ_CMD;
        hold_s   = 1'b1;
      end
      S_ADDR: begin
        launch_s = 1'b1;
        byte_s   = address_r;
        hold_s   = 1'b1;
      end
      S_DATA: begin
        launch_s = 1'b1;
        byte_s   = write_r ? data_r : 8'h00;
        hold_s   = 1'b0;
      end
      default: begin
        launch_s = 1'b0;
        byte_s   = 8'h00;
        hold_s   = 1'b0;
      end
    endcase
  end

  // Registered outputs, request latches and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_r       <= 1'b0;
      address_r     <= 8'h00;
      data_r        <= 8'h00;
      busy          <= 1'b0;
      done          <= 1'b0;
      data_received <= 8'h00;
      spi_start     <= 1'b0;
      spi_data      <= 8'h00;
      spi_hold_cs   <= 1'b0;
    end else begin
      if ((state_r == S_IDLE) && start) begin
        write_r   <= write;
        address_r <= address;
        data_r    <= data_to_send;
      end
      busy      <= (next_state_s != S_IDLE);
      done      <= (next_state_s == S_DONE);
      spi_start <= launch_s;
      // spi_data / spi_hold_cs stay stable while waiting on the SPI byte.
      if (launch_s) begin
        spi_data    <= byte_s;
        spi_hold_cs <= hold_s;
      end
      if ((state_r == S_DATA_WAIT) && spi_done && !write_r) begin
        data_received <= spi_data_received;
      end
    end
  end

endmodule

// File: tb/tb_adxl362_controller.sv
// Testbench for adxl362_controller: directed table of transactions, hand
// sequences for spurious spi_done and mid-transaction reset, then random
// transactions checked against a transaction-level reference model.
module tb_adxl362_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       write = 1'b0;
  logic [7:0] address = 8'h00;
  logic [7:0] data_to_send = 8'h00;
  logic       busy;
  logic       done;
  logic [7:0] data_received;
  logic       spi_start;
  logic [7:0] spi_data;
  logic       spi_hold_cs;
  logic       spi_done = 1'b0;
  logic [7:0] spi_data_received = 8'h00;

  int tests = 0;
  int fails = 0;

  adxl362_controller dut (
    .clk(clk), .rst(rst), .start(start), .write(write), .address(address),
    .data_to_send(data_to_send), .busy(busy), .done(done),
    .data_received(data_received), .spi_start(spi_start), .spi_data(spi_data),
    .spi_hold_cs(spi_hold_cs), .spi_done(spi_done),
    .spi_data_received(spi_data_received)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] resp;
    int         l0;
    int         l1;
    int         l2;
    logic       poke;
    logic       spur;
    logic [7:0] exp_rx;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One full transaction. Called at a negedge with the DUT idle; returns at
  // the negedge of the cycle after done, so a following call is back-to-back.
  task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] resp, input int l0, input int l1,
                         input int l2, input logic poke, input logic spur,
                         input logic [7:0] exp_rx);
    logic [7:0] eb [3];
    logic       eh [3];
    int         lat [3];
    int         cyc;
    int         tgt;
    int         wn;
    logic       ok;
    eb[0] = w ? 8'h0A : 8'h0B;
    eb[1] = a;
    eb[2] = w ? d : 8'h00;
    eh[0] = 1'b1; eh[1] = 1'b1; eh[2] = 1'b0;
    lat[0] = l0; lat[1] = l1; lat[2] = l2;
    start = 1'b1; write = w; address = a; data_to_send = d;
    cyc = 0;
    @(negedge clk); cyc++; start = 1'b0;
    tgt = 1;
    for (int i = 0; i < 3; i++) begin
      wn = 0;
      while (spi_start !== 1'b1 && wn < 16) begin
        @(negedge clk); cyc++; wn++;
      end
      check("byte_time", 32'(cyc), 32'(tgt));
      check("byte_data", 32'(spi_data), 32'(eb[i]));
      check("byte_cs", 32'(spi_hold_cs), 32'(eh[i]));
      check("byte_busy", 32'(busy), 32'd1);
      spi_done = (i == 1) && spur;
      ok = 1'b1;
      for (int k = 1; k <= lat[i]; k++) begin
        @(negedge clk); cyc++;
        if (spi_start !== 1'b0 || spi_data !== eb[i] || spi_hold_cs !== eh[i] ||
            busy !== 1'b1 || done !== 1'b0) ok = 1'b0;
        start = poke && (i == 0) && (k == 1);
        if (start) begin
          address = 8'h1F;
          write = ~w;
        end
        spi_done = (k == lat[i]);
        spi_data_received = (i == 2) ? resp : 8'($urandom);
      end
      check("byte_wait_stable", 32'(ok), 32'd1);
      @(negedge clk); cyc++; spi_done = 1'b0; start = 1'b0;
      tgt = cyc;
    end
    wn = 0;
    while (done !== 1'b1 && wn < 16) begin
      @(negedge clk); cyc++; wn++;
    end
    check("done_latency", 32'(cyc), 32'(4 + l0 + l1 + l2));
    check("done_busy", 32'(busy), 32'd1);
    check("data_received", 32'(data_received), 32'(exp_rx));
    @(negedge clk);
    check("after_done", 32'({done, busy, spi_start}), 32'd0);
  endtask

  vec_t       vecs [6];
  logic [7:0] model_rx;
  logic       ok;

  initial begin
    vecs[0] = '{1'b1, 8'h2D, 8'h02, 8'h55, 2, 3, 1, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 8'h00, 8'h77, 8'hAD, 1, 1, 1, 1'b0, 1'b0, 8'hAD};
    vecs[2] = '{1'b1, 8'h2C, 8'h0A, 8'h66, 3, 2, 2, 1'b1, 1'b0, 8'hAD};
    vecs[3] = '{1'b0, 8'h01, 8'h00, 8'h1D, 2, 1, 3, 1'b0, 1'b0, 8'h1D};
    vecs[4] = '{1'b0, 8'h02, 8'h00, 8'hF2, 1, 2, 2, 1'b0, 1'b0, 8'hF2};
    vecs[5] = '{1'b1, 8'h1F, 8'h11, 8'h99, 1, 3, 2, 1'b0, 1'b1, 8'hF2};

    // Reset values while rst is held.
    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({busy, done, spi_start, spi_hold_cs}), 32'd0);
    check("rst_spi_data", 32'(spi_data), 32'h00);
    check("rst_rx", 32'(data_received), 32'h00);
    rst = 1'b0;
    @(negedge clk);

    // Directed table; entries 3 and 4 run back-to-back.
    for (int v = 0; v < 6; v++) begin
      run_txn(vecs[v].w, vecs[v].a, vecs[v].d, vecs[v].resp, vecs[v].l0,
              vecs[v].l1, vecs[v].l2, vecs[v].poke, vecs[v].spur, vecs[v].exp_rx);
    end

    // Spurious spi_done while idle.
    spi_done = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 1) spi_done = 1'b0;
      if (busy !== 1'b0 || spi_start !== 1'b0 || done !== 1'b0) ok = 1'b0;
    end
    check("idle_spurious", 32'(ok), 32'd1);
    check("idle_rx_hold", 32'(data_received), 32'hF2);

    // Reset while waiting for the address byte.
    start = 1'b1; write = 1'b1; address = 8'h22; data_to_send = 8'h33;
    @(negedge clk); start = 1'b0;
    check("rst_seq_cmd", 32'(spi_start), 32'd1);
    @(negedge clk); spi_done = 1'b1;
    @(negedge clk); spi_done = 1'b0;
    check("rst_seq_addr", 32'({spi_start, spi_data}), 32'h122);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst_mid_ctrl", 32'({busy, done, spi_start, spi_hold_cs}), 32'd0);
    check("rst_mid_data", 32'({spi_data, data_received}), 32'h0000);
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || spi_start !== 1'b0) ok = 1'b0;
    end
    check("rst_mid_quiet", 32'(ok), 32'd1);
    model_rx = 8'h00;
    run_txn(1'b1, 8'h2D, 8'h02, 8'h44, 2, 2, 2, 1'b0, 1'b0, model_rx);

    // Random transactions against the transaction-level model.
    for (int n = 0; n < 40; n++) begin
      logic       w;
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] r;
      w = 1'($urandom);
      a = 8'($urandom);
      d = 8'($urandom);
      r = 8'($urandom);
      if (!w) model_rx = r;
      run_txn(w, a, d, r, int'($urandom_range(5, 1)), int'($urandom_range(5, 1)),
              int'($urandom_range(5, 1)), 1'($urandom), 1'($urandom), model_rx);
      if (($urandom % 3) == 0) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
